core_dispatch_queue: RTL and testbench
======================================

Name: core_dispatch_queue

Overview:
- In-order dual-entry-wide instruction queue between decode and dispatch hazard logic.
- Accepts up to two decoded instructions per cycle from decode.
- Always presents the two oldest entries as cur_a/cur_b to the hazard checker.
- Retires them according to dispatch_a/dispatch_b; flushed on redirect (taken branch/exception).

Parameters:
DEPTH, 8, queue entries; power of two, minimum 4.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
in_a  input  insn_decode  older decoded instruction from decode
in_b  input  insn_decode  younger decoded instruction from decode
in_valid_a  input  1  in_a present
in_valid_b  input  1  in_b present; only meaningful with in_valid_a
in_ready  output  1  queue can take two instructions this cycle
flush  input  1  discard all queued and incoming instructions
dispatch_a  input  1  head entry issued this cycle
dispatch_b  input  1  head+1 entry issued this cycle
cur_a  output  insn_decode  head entry, presented to hazard checker
cur_b  output  insn_decode  head+1 entry
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: DEPTH-entry circular buffer of insn_decode.
  - rd_ptr and wr_ptr are $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count is the occupancy register.
- Reset (async, rst_n low):
  - rd_ptr = wr_ptr = 0, count = 0, in_ready = 1.
  - cur_a.ctrl.execute = cur_b.ctrl.execute = 0.
  - Entry contents are don't-care.
  - Reset asserted mid-stream discards everything immediately.
- in_ready is combinational from the registered count only: in_ready = (DEPTH - count >= 2).
  - Same-cycle dequeue does not raise in_ready, so no combinational path from dispatch_* to in_ready.
- Enqueue acceptance:
  - Input handshake is accepted when in_ready && in_valid_a && !flush.
  - Decode must hold inputs while in_ready = 0.
- Enqueue squash/compaction:
  - A lane whose ctrl.execute = 0 is not written, so the hazard checker never sees a non-executing head and cannot deadlock.
  - in_valid_b without in_valid_a is ignored.
  - enq_n = number of written lanes (0..2).
  - If only lane b qualifies, it is written at wr_ptr.
  - If both qualify, a goes at wr_ptr and b at wr_ptr+1.
- Dequeue:
  - deq_n = dispatch_a + (dispatch_a & dispatch_b).
  - dispatch_b without dispatch_a is ignored (deq_n = 0).
  - dispatch_a with count = 0, or dispatch_b with count < 2, is a protocol error. Assertion fires in simulation; the extra pop is ignored.
- Update:
  - count' = count + enq_n - deq_n.
  - rd_ptr += deq_n, wr_ptr += enq_n.
  - Simultaneous enqueue and dequeue is legal in every occupancy state.
- Flush (priority over all):
  - Next cycle count = 0 and rd_ptr = wr_ptr.
  - Same-cycle inputs are dropped; same-cycle dispatch_* is irrelevant to queue state.
- Outputs, combinational from registered state:
  - cur_a = mem[rd_ptr], with ctrl.execute forced to 0 when count = 0.
  - cur_b = mem[rd_ptr+1], with ctrl.execute forced to 0 when count < 2.
  - Forcing applies only to ctrl.execute; other fields pass through.
- Latency: an instruction enqueued in cycle N appears on cur_a/cur_b in cycle N+1 at the earliest; no bypass.
- Ordering: strict program order; cur_a is always older than cur_b.

Optional Feature:
DISPATCH_QUEUE_PERF_EN:
- When defined, adds three 32-bit saturating output counters, zeroed by rst_n:
  - perf_dual: cycles with deq_n = 2.
  - perf_single: cycles with deq_n = 1.
  - perf_stall: cycles with count > 0 && !dispatch_a && !flush.
- Undefined: the ports and logic are absent, with no other behavioural difference.

Test Plan:
- Reset: hold rst_n = 0 mid-cycle, release → count = 0, in_ready = 1, cur_a/cur_b execute = 0.
- Fill: enqueue pairs (I0,I1),(I2,I3),(I4,I5) with no dispatch → count 2,4,6, in_ready stays 1. Next pair gives count = 8 and in_ready = 0; further in_valid is ignored and count stays 8.
- Dual drain: from count = 8 assert dispatch_a = dispatch_b = 1 → cur_a/cur_b step I0/I1, I2/I3, ... Pointers wrap correctly after index 7; count reaches 0 after 4 cycles.
- Single/mixed: with count = 3, dispatch_a only → count 2, cur_a = I1. Simultaneous enqueue of 2 plus dispatch of 2 → count unchanged, order preserved.
- Squash: in_a.ctrl.execute = 0 with in_b valid → only in_b enqueued, count += 1, and cur_a = in_b next cycle.
- Flush: count = 5, flush = 1 together with in_valid_a = 1 and dispatch_a = 1 → next cycle count = 0, execute outputs 0, and the new input is not present.

Source files
------------

// File: rtl/core_dispatch_queue.sv
// core_dispatch_queue: in-order, two-wide instruction queue sitting between
// decode and the dispatch hazard checker. Decode pushes up to two decoded
// instructions per cycle; the two oldest entries are always presented as
// cur_a/cur_b and retired by dispatch_a/dispatch_b. A flush empties the queue.
//
// Optional build macro: DISPATCH_QUEUE_PERF_EN adds three saturating
// 32-bit performance counters (perf_dual, perf_single, perf_stall).

package core_dispatch_queue_pkg;

  // Control bits produced by decode. Only 'execute' is interpreted here.
  typedef struct packed {
    logic execute;
    logic is_branch;
    logic is_mem;
    logic writes_rd;
  } insn_ctrl_t;

  // Decoded instruction as carried through the queue.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] raw;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    insn_ctrl_t  ctrl;
  } insn_decode;

endpackage

module core_dispatch_queue
  import core_dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  insn_decode               in_a,
  input  insn_decode               in_b,
  input  logic                     in_valid_a,
  input  logic                     in_valid_b,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     dispatch_a,
  input  logic                     dispatch_b,
  output insn_decode               cur_a,
  output insn_decode               cur_b,
  output logic [$clog2(DEPTH):0]   count
`ifdef DISPATCH_QUEUE_PERF_EN
  ,
  output logic [31:0]              perf_dual,
  output logic [31:0]              perf_single,
  output logic [31:0]              perf_stall
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  insn_decode    mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  logic          accept;
  logic          wr_a;
  logic          wr_b;
  logic [1:0]    enq_n;
  logic [1:0]    deq_n;
  logic [PW-1:0] wr_idx_b;
  logic [PW-1:0] rd_ptr_p1;

  // Room for a full pair is judged on registered occupancy only, so a
  // same-cycle dispatch never reaches in_ready combinationally.
  assign in_ready  = (count_q <= CW'(DEPTH - 2));
  assign count     = count_q;
  assign rd_ptr_p1 = rd_ptr_q + PW'(1);

  // Enqueue qualification and compaction: non-executing lanes are dropped so
  // the head the hazard checker sees is always something it can issue.
  always_comb begin
    accept   = in_ready && in_valid_a && !flush;
    wr_a     = accept && in_a.ctrl.execute;
    wr_b     = accept && in_valid_b && in_b.ctrl.execute;
    enq_n    = {1'b0, wr_a} + {1'b0, wr_b};
    // Lane b slides down into wr_ptr when lane a was squashed.
    wr_idx_b = wr_a ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
  end

  // Dequeue count: dispatch_b only counts alongside dispatch_a, and pops
  // beyond the current occupancy are dropped rather than corrupting state.
  always_comb begin
    deq_n = 2'd0;
    if (dispatch_a && (count_q != '0)) begin
      deq_n = 2'd1;
      if (dispatch_b && (count_q >= CW'(2))) begin
        deq_n = 2'd2;
      end
    end
  end

  // Next-state for pointers and occupancy; flush wins over everything.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(deq_n);
      wr_ptr_d = wr_ptr_q + PW'(enq_n);
      count_d  = count_q + CW'(enq_n) - CW'(deq_n);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  // The two write indices can never coincide in the same cycle.
  always_ff @(posedge clk) begin
    if (wr_a) begin
      mem_q[wr_ptr_q] <= in_a;
    end
    if (wr_b) begin
      mem_q[wr_idx_b] <= in_b;
    end
  end

  // Head/head+1 presentation; only the execute bit is masked for empty slots.
  always_comb begin
    cur_a              = mem_q[rd_ptr_q];
    cur_b              = mem_q[rd_ptr_p1];
    cur_a.ctrl.execute = mem_q[rd_ptr_q].ctrl.execute  && (count_q != '0);
    cur_b.ctrl.execute = mem_q[rd_ptr_p1].ctrl.execute && (count_q >= CW'(2));
  end

`ifdef DISPATCH_QUEUE_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------------
  logic [31:0] perf_dual_q, perf_single_q, perf_stall_q;
  logic        eff_dual, eff_single, eff_stall;

  // Dispatch during a flush does not retire anything, so it is not counted.
  always_comb begin
    eff_dual   = !flush && (deq_n == 2'd2);
    eff_single = !flush && (deq_n == 2'd1);
    eff_stall  = (count_q != '0) && !dispatch_a && !flush;
  end

  // Counter registers, each holding at all-ones once saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_dual_q   <= '0;
      perf_single_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (eff_dual && (perf_dual_q != '1)) begin
        perf_dual_q <= perf_dual_q + 32'd1;
      end
      if (eff_single && (perf_single_q != '1)) begin
        perf_single_q <= perf_single_q + 32'd1;
      end
      if (eff_stall && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_dual   = perf_dual_q;
  assign perf_single = perf_single_q;
  assign perf_stall  = perf_stall_q;
`endif

`ifndef SYNTHESIS
  // Protocol checks: popping more than is present, or overfilling.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!(dispatch_a && (count_q == '0)))
        else $error("core_dispatch_queue: dispatch_a with empty queue");
      assert (!(dispatch_b && (count_q < CW'(2))))
        else $error("core_dispatch_queue: dispatch_b with fewer than two entries");
      assert (count_d <= CW'(DEPTH))
        else $error("core_dispatch_queue: occupancy overflow");
    end
  end
`endif

endmodule

// File: tb/tb_core_dispatch_queue.sv
// Directed-vector bench for core_dispatch_queue. Stimulus pushes the
// hand-computed state expected after each clock edge into a queue; a
// monitor pops one record per falling edge and compares it with the DUT.

module tb_core_dispatch_queue;
  import core_dispatch_queue_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  insn_decode in_a, in_b;
  logic       in_valid_a, in_valid_b;
  logic       in_ready;
  logic       flush;
  logic       dispatch_a, dispatch_b;
  insn_decode cur_a, cur_b;
  logic [$clog2(DEPTH):0] count;
`ifdef DISPATCH_QUEUE_PERF_EN
  logic [31:0] perf_dual, perf_single, perf_stall;
`endif

  always #5 clk = ~clk;

  core_dispatch_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_valid_a (in_valid_a),
    .in_valid_b (in_valid_b),
    .in_ready   (in_ready),
    .flush      (flush),
    .dispatch_a (dispatch_a),
    .dispatch_b (dispatch_b),
    .cur_a      (cur_a),
    .cur_b      (cur_b),
    .count      (count)
`ifdef DISPATCH_QUEUE_PERF_EN
    ,
    .perf_dual  (perf_dual),
    .perf_single(perf_single),
    .perf_stall (perf_stall)
`endif
  );

  typedef struct {
    int id;
    int cnt;
    bit rdy;
    bit ae;
    int at;
    bit be;
    int bt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   step_no = 0;

  function automatic insn_decode mk(int tag, bit ex);
    insn_decode d;
    d              = '0;
    d.pc           = tag;
    d.raw          = 32'h0000_0013 ^ tag;
    d.rd           = tag[4:0];
    d.ctrl.execute = ex;
    return d;
  endfunction

  task automatic chk(int id, string nm, int act, int req);
    n_vec++;
    if (act != req) begin
      n_miss++;
      $display("FAIL step %0d %s: got %0d, required %0d", id, nm, act, req);
    end
  endtask

  // One clock of stimulus, then queue the state expected after that edge.
  task automatic cyc(bit va, int at, bit aex, bit vb, int bt, bit bex,
                     bit da, bit db, bit fl,
                     int ec, bit er, bit eae, int eat, bit ebe, int ebt);
    exp_t e;
    in_valid_a = va;  in_a = mk(at, aex);
    in_valid_b = vb;  in_b = mk(bt, bex);
    dispatch_a = da;  dispatch_b = db;  flush = fl;
    @(posedge clk);
    #1;
    e.id = step_no; e.cnt = ec; e.rdy = er;
    e.ae = eae; e.at = eat; e.be = ebe; e.bt = ebt;
    exp_q.push_back(e);
    step_no++;
  endtask

  task automatic idle_in();
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_a = '0; in_b = '0;
    dispatch_a = 1'b0; dispatch_b = 1'b0; flush = 1'b0;
  endtask

  // Monitor: compare one expected record per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      $display("step %0d: count=%0d ready=%0d a=%0d/%0d b=%0d/%0d", mon_e.id,
               count, in_ready, cur_a.ctrl.execute, cur_a.pc,
               cur_b.ctrl.execute, cur_b.pc);
      chk(mon_e.id, "count", int'(count), mon_e.cnt);
      chk(mon_e.id, "in_ready", int'(in_ready), int'(mon_e.rdy));
      chk(mon_e.id, "cur_a.execute", int'(cur_a.ctrl.execute), int'(mon_e.ae));
      chk(mon_e.id, "cur_b.execute", int'(cur_b.ctrl.execute), int'(mon_e.be));
      if (mon_e.ae) chk(mon_e.id, "cur_a.pc", int'(cur_a.pc), mon_e.at);
      if (mon_e.be) chk(mon_e.id, "cur_b.pc", int'(cur_b.pc), mon_e.bt);
    end
  end

  initial begin
    int wait_cycles;
    rst_n = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;                      // release mid-cycle

    // Reset state.
    cyc(0,0,0, 0,0,0, 0,0,0,   0,1, 0,0,   0,0);
    // Fill with pairs; the fifth pair is held off by in_ready = 0.
    cyc(1,100,1, 1,101,1, 0,0,0,   2,1, 1,100, 1,101);
    cyc(1,102,1, 1,103,1, 0,0,0,   4,1, 1,100, 1,101);
    cyc(1,104,1, 1,105,1, 0,0,0,   6,1, 1,100, 1,101);
    cyc(1,106,1, 1,107,1, 0,0,0,   8,0, 1,100, 1,101);
    cyc(1,108,1, 1,109,1, 0,0,0,   8,0, 1,100, 1,101);
    // Dual drain to empty.
    cyc(0,0,0, 0,0,0, 1,1,0,   6,1, 1,102, 1,103);
    cyc(0,0,0, 0,0,0, 1,1,0,   4,1, 1,104, 1,105);
    cyc(0,0,0, 0,0,0, 1,1,0,   2,1, 1,106, 1,107);
    cyc(0,0,0, 0,0,0, 1,1,0,   0,1, 0,0,   0,0);
    // Build count = 3, single dispatch, then enqueue-2 with dispatch-2.
    cyc(1,110,1, 1,111,1, 0,0,0,   2,1, 1,110, 1,111);
    cyc(1,112,1, 0,0,0,   0,0,0,   3,1, 1,110, 1,111);
    cyc(0,0,0, 0,0,0, 1,0,0,       2,1, 1,111, 1,112);
    cyc(1,113,1, 1,114,1, 1,1,0,   2,1, 1,113, 1,114);
    // Fill across the pointer wrap and drain through it.
    cyc(1,115,1, 1,116,1, 0,0,0,   4,1, 1,113, 1,114);
    cyc(1,117,1, 1,118,1, 0,0,0,   6,1, 1,113, 1,114);
    cyc(0,0,0, 0,0,0, 1,1,0,       4,1, 1,115, 1,116);
    cyc(0,0,0, 0,0,0, 1,1,0,       2,1, 1,117, 1,118);
    cyc(0,0,0, 0,0,0, 1,0,0,       1,1, 1,118, 0,0);
    cyc(0,0,0, 0,0,0, 1,0,0,       0,1, 0,0,   0,0);
    // dispatch_b alone is ignored.
    cyc(1,119,1, 1,120,1, 0,0,0,   2,1, 1,119, 1,120);
    cyc(0,0,0, 0,0,0, 0,1,0,       2,1, 1,119, 1,120);
    cyc(0,0,0, 0,0,0, 1,1,0,       0,1, 0,0,   0,0);
    // Squash: non-executing lanes are not written; b alone is ignored.
    cyc(1,121,0, 1,122,1, 0,0,0,   1,1, 1,122, 0,0);
    cyc(1,123,1, 1,124,0, 0,0,0,   2,1, 1,122, 1,123);
    cyc(1,125,0, 1,126,0, 0,0,0,   2,1, 1,122, 1,123);
    cyc(0,127,1, 1,128,1, 0,0,0,   2,1, 1,122, 1,123);
    // Flush at count = 5 with a same-cycle input and dispatch.
    cyc(1,129,1, 1,130,1, 0,0,0,   4,1, 1,122, 1,123);
    cyc(1,131,1, 0,0,0,   0,0,0,   5,1, 1,122, 1,123);
    cyc(1,132,1, 1,133,1, 1,0,1,   0,1, 0,0,   0,0);
    cyc(0,0,0, 0,0,0, 0,0,0,       0,1, 0,0,   0,0);
    cyc(1,134,1, 1,135,1, 0,0,0,   2,1, 1,134, 1,135);
    // count = 7 blocks a pair; dispatch then frees room next cycle.
    cyc(1,136,1, 1,137,1, 0,0,0,   4,1, 1,134, 1,135);
    cyc(1,138,1, 0,0,0,   0,0,0,   5,1, 1,134, 1,135);
    cyc(1,139,1, 1,140,1, 0,0,0,   7,0, 1,134, 1,135);
    cyc(1,141,1, 1,142,1, 1,0,0,   6,1, 1,135, 1,136);
    cyc(1,141,1, 1,142,1, 1,1,0,   6,1, 1,137, 1,138);

    // Asynchronous reset mid-stream: observed before any clock edge.
    @(negedge clk);
    idle_in();
    #1 rst_n = 1'b0;
    #1;
    chk(step_no, "async_rst count", int'(count), 0);
    chk(step_no, "async_rst in_ready", int'(in_ready), 1);
    chk(step_no, "async_rst cur_a.execute", int'(cur_a.ctrl.execute), 0);
    chk(step_no, "async_rst cur_b.execute", int'(cur_b.ctrl.execute), 0);
    step_no++;
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(0,0,0, 0,0,0, 0,0,0,       0,1, 0,0,   0,0);
    cyc(1,150,1, 1,151,1, 0,0,0,   2,1, 1,150, 1,151);
    idle_in();

    // Let the monitor drain the scoreboard, bounded.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: %0d records left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
